data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WIDTH, default 32: data and address width.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of WIDTH-bit words in the storage array.
REQ-003 Parameter LATENCY, default 2, legal range 1..15: cycles from request acceptance to rsp_valid.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  memory-stage request present.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  WIDTH  byte address.
REQ-010 req_wdata  input  WIDTH  store data, right-aligned.
REQ-011 req_load_type  input  3  001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; other codes illegal.
REQ-012 req_store_type  input  2  01 SB, 10 SH, 11 SW; 00 illegal.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  initiator accepts the response.
REQ-015 rsp_rdata  output  WIDTH  extended load data; 0 for stores and errors.
REQ-016 rsp_error  output  1  request was rejected.

Function
REQ-017 FSM states: IDLE, WAIT, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE.
REQ-019 Acceptance: req_valid & req_ready at a rising edge. On acceptance the FSM SHALL load the down-counter with LATENCY-1 and go to WAIT, or go directly to RESP when LATENCY=1.
REQ-020 In WAIT the counter SHALL decrement each cycle. The FSM SHALL go to RESP when the counter is 0.
REQ-021 rsp_valid SHALL be 1 only in RESP, first asserted exactly LATENCY cycles after the acceptance edge.
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_error SHALL hold stable until rsp_valid & rsp_ready. On that edge the FSM SHALL return to IDLE.
REQ-023 A new request is not accepted in the same cycle as a response handshake; back-to-back throughput is one request per LATENCY+1 cycles minimum.
REQ-024 Word index = req_addr[log2(DEPTH_WORDS)+1:2]. Byte lane = req_addr[1:0].
REQ-025 Error conditions:
- LH, LHU or SH with addr[0]=1.
- LW or SW with addr[1:0]≠0.
- req_addr ≥ 4*DEPTH_WORDS.
- Illegal load or store type code.
REQ-026 On an error request: no array write, rsp_error=1, rsp_rdata=0.
REQ-027 Store without error: the array SHALL be updated on the acceptance edge, writing only the addressed byte or half-word lanes from req_wdata LSBs. Other lanes are unchanged.
REQ-028 Load without error: the addressed word SHALL be captured on the acceptance edge, so a load sees every store accepted earlier.
REQ-029 Load extraction: LB/LH sign-extend the selected lane to WIDTH. LBU/LHU zero-extend. LW returns the full word.
REQ-030 A store response SHALL have rsp_rdata=0 and rsp_error=0.
REQ-031 Captured request fields SHALL be registered at acceptance; input changes after acceptance have no effect.
REQ-032 The storage array SHALL NOT be reset. Read-before-write contents are undefined in simulation (X allowed).

Reset
REQ-033 While rst=0: FSM=IDLE, counter=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, req_ready=0.
REQ-034 After rst deassertion, req_ready SHALL be 1 from the first rising edge onward.
REQ-035 If reset asserts mid-transaction (WAIT or RESP), the pending response SHALL be discarded. A store already accepted remains written.

Verification
REQ-036 LATENCY=2: SW addr 0x10, data 0xDEADBEEF → rsp_valid two cycles after acceptance, rdata 0, error 0. Then LW 0x10 → rdata 0xDEADBEEF.
REQ-037 After REQ-036: SB addr 0x11, data 0x80 then LB 0x11 → 0xFFFFFF80. LBU 0x11 → 0x00000080. LH 0x12 → 0xFFFFDEAD. LHU 0x10 → 0x000080EF.
REQ-038 LW 0x13, SH 0x21 and LW 0x1000 (DEPTH 1024) → each rsp_error=1, rdata 0. A following LW 0x20 shows the word unchanged.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rdata and error stable, req_ready=0. Raise rsp_ready → IDLE next cycle, req_ready=1.
REQ-040 Assert rst=0 asynchronously mid-WAIT after an accepted LW → rsp_valid=0 immediately and no response after release. A store accepted before reset reads back correctly.
REQ-041 LATENCY=1 build: LW accepted at edge N → rsp_valid high in the cycle following edge N. Run random load/store traffic against a reference byte-array model.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised storage with byte/half/word access,
// fixed request-to-response latency and a valid/ready response handshake.
module data_mem_responder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [2:0]       req_load_type,
    input  logic [1:0]       req_store_type,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_error
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [WIDTH:0] ADDR_LIMIT = (WIDTH+1)'(64'(DEPTH_WORDS) * 64'd4);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] LOAD_LB  = 3'b001;
    localparam logic [2:0] LOAD_LH  = 3'b010;
    localparam logic [2:0] LOAD_LW  = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [1:0] STORE_SB = 2'b01;
    localparam logic [1:0] STORE_SH = 2'b10;
    localparam logic [1:0] STORE_SW = 2'b11;

    logic [WIDTH-1:0] mem [DEPTH_WORDS];

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_error_q, rsp_error_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [IDX_W-1:0] idx_c;
    logic [1:0]       lane_c;
    logic [4:0]       shift_c;
    logic [WIDTH-1:0] rd_word_c;
    logic [15:0]      rd_half_c;
    logic [WIDTH-1:0] load_val_c;
    logic             load_err_c;
    logic [NB-1:0]    store_be_c;
    logic             store_err_c;
    logic [WIDTH-1:0] store_data_c;
    logic             addr_oob_c;
    logic             req_err_c;
    logic             accept_c;
    logic             mem_we_c;

    assign idx_c        = req_addr[IDX_W+1:2];
    assign lane_c       = req_addr[1:0];
    assign shift_c      = {lane_c, 3'b000};
    assign rd_word_c    = mem[idx_c];
    assign rd_half_c    = 16'(rd_word_c >> shift_c);
    assign store_data_c = req_wdata << shift_c;
    assign addr_oob_c   = {1'b0, req_addr} >= ADDR_LIMIT;
    assign accept_c     = req_valid & req_ready_q;
    assign req_err_c    = addr_oob_c | (req_write ? store_err_c : load_err_c);
    assign mem_we_c     = accept_c & req_write & ~req_err_c;

    // Load lane extraction and alignment check
    always_comb begin
        load_err_c = 1'b0;
        load_val_c = '0;
        case (req_load_type)
            LOAD_LB:  load_val_c = {{(WIDTH-8){rd_half_c[7]}}, rd_half_c[7:0]};
            LOAD_LBU: load_val_c = WIDTH'(rd_half_c[7:0]);
            LOAD_LH: begin
                load_err_c = lane_c[0];
                load_val_c = {{(WIDTH-16){rd_half_c[15]}}, rd_half_c};
            end
            LOAD_LHU: begin
                load_err_c = lane_c[0];
                load_val_c = WIDTH'(rd_half_c);
            end
            LOAD_LW: begin
                load_err_c = (lane_c != 2'b00);
                load_val_c = rd_word_c;
            end
            default: load_err_c = 1'b1;
        endcase
    end

    // Store byte enables and alignment check
    always_comb begin
        store_err_c = 1'b0;
        store_be_c  = '0;
        case (req_store_type)
            STORE_SB: store_be_c = NB'(1) << lane_c;
            STORE_SH: begin
                store_err_c = lane_c[0];
                store_be_c  = NB'(3) << lane_c;
            end
            STORE_SW: begin
                store_err_c = (lane_c != 2'b00);
                store_be_c  = '1;
            end
            default: store_err_c = 1'b1;
        endcase
    end

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (store_be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= store_data_c[8*b +: 8];
                end
            end
        end
    end

    // Next-state and response payload
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_error_d = rsp_error_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    rsp_error_d = req_err_c;
                    rsp_rdata_d = (req_err_c || req_write) ? '0 : load_val_c;
                    if (LATENCY <= 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (latency 2 and 1) driven by
// directed and random traffic, checked by a queue scoreboard against a byte-array model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned BYTES = 4 * DEPTH;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid      [2];
    logic        req_ready      [2];
    logic        req_write      [2];
    logic [31:0] req_addr       [2];
    logic [31:0] req_wdata      [2];
    logic [2:0]  req_load_type  [2];
    logic [1:0]  req_store_type [2];
    logic        rsp_valid      [2];
    logic        rsp_ready      [2];
    logic [31:0] rsp_rdata      [2];
    logic        rsp_error      [2];

    exp_t        exp_q   [2][$];
    logic [7:0]  ref_mem [2][BYTES];
    bit          in_rsp  [2];
    int          rdy_mode [2];
    int          vectors = 0;
    int          miscompares = 0;
    int          edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_load_type(req_load_type[0]), .req_store_type(req_store_type[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
    );

    data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_load_type(req_load_type[1]), .req_store_type(req_store_type[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat little-endian byte array
    function automatic void model(input int d, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] lt,
                                  input logic [1:0] st, output logic [31:0] data,
                                  output logic err);
        int n = 0;
        bit sgn = 0;
        int base;
        logic [31:0] v;
        if (wr) begin
            case (st)
                2'd1: n = 1;
                2'd2: n = 2;
                2'd3: n = 4;
                default: n = 0;
            endcase
        end else begin
            case (lt)
                3'd1: begin n = 1; sgn = 1; end
                3'd2: begin n = 2; sgn = 1; end
                3'd3: n = 4;
                3'd4: n = 1;
                3'd5: n = 2;
                default: n = 0;
            endcase
        end
        data = 32'd0;
        if (n == 0) err = 1'b1;
        else err = (addr >= 32'(BYTES)) || ((addr % n) != 0);
        if (err) return;
        base = int'(addr);
        if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[d][base + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[d][base + i]) << (8 * i));
            if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            data = v;
        end
    endfunction

    task automatic issue(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] lt, input logic [1:0] st,
                         input bit use_exp, input logic [31:0] xdata, input logic xerr);
        exp_t e;
        logic [31:0] md;
        logic me;
        int n = 0;
        @(posedge clk); #1;
        req_write[d] = wr;
        req_addr[d] = addr;
        req_wdata[d] = wdata;
        req_load_type[d] = lt;
        req_store_type[d] = st;
        req_valid[d] = 1'b1;
        @(negedge clk);
        while (!req_ready[d] && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready[d]) begin
            vectors++;
            miscompares++;
            $display("FAIL req_ready_timeout_%0d: got req_ready 0 for 100 cycles, expected 1", d);
            req_valid[d] = 1'b0;
            return;
        end
        model(d, wr, addr, wdata, lt, st, md, me);
        e.data = use_exp ? xdata : md;
        e.err  = use_exp ? xerr : me;
        e.acc  = edge_cnt + 1;
        exp_q[d].push_back(e);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_write[d] = 1'($urandom);
        req_addr[d] = $urandom;
        req_wdata[d] = $urandom;
        req_load_type[d] = 3'($urandom);
        req_store_type[d] = 2'($urandom);
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        while (exp_q[d].size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (exp_q[d].size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout_%0d: got %0d responses outstanding, expected 0", d, exp_q[d].size());
            exp_q[d].delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_req_ready_%0d", tag, d), 32'(req_ready[d]), 32'd0);
            check($sformatf("%s_rsp_valid_%0d", tag, d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("%s_rsp_error_%0d", tag, d), 32'(rsp_error[d]), 32'd0);
            check($sformatf("%s_rsp_rdata_%0d", tag, d), rsp_rdata[d], 32'd0);
        end
    endtask

    task automatic reset_pulse_after_accept(input int d);
        #2 rst = 1'b0;
        #1 check_reset_outputs("mid_txn_reset");
        exp_q[d].delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset_pulse", 32'(req_ready[d]), 32'd1);
    endtask

    // Response-ready pattern per instance: 0 random, 1 held low, 2 held high
    initial begin
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                case (rdy_mode[d])
                    0: rsp_ready[d] = ($urandom_range(0, 3) != 0);
                    1: rsp_ready[d] = 1'b0;
                    default: rsp_ready[d] = 1'b1;
                endcase
            end
        end
    end

    // Scoreboard monitor: compare every presented response cycle against the queue head
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                in_rsp[d] = 1'b0;
            end else if (rsp_valid[d]) begin
                check($sformatf("busy_req_ready_%0d", d), 32'(req_ready[d]), 32'd0);
                if (exp_q[d].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp_%0d: got rdata 0x%08h error %0d, expected no response",
                             d, rsp_rdata[d], rsp_error[d]);
                end else begin
                    e = exp_q[d][0];
                    if (!in_rsp[d]) begin
                        check($sformatf("latency_%0d", d), 32'(edge_cnt - e.acc + 1),
                              32'((d == 0) ? LAT0 : LAT1));
                        in_rsp[d] = 1'b1;
                    end
                    check($sformatf("rsp_rdata_%0d", d), rsp_rdata[d], e.data);
                    check($sformatf("rsp_error_%0d", d), 32'(rsp_error[d]), 32'(e.err));
                    if (rsp_ready[d]) begin
                        void'(exp_q[d].pop_front());
                        in_rsp[d] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  lt;
        logic [1:0]  st;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d] = '0;
            req_wdata[d] = '0;
            req_load_type[d] = 3'd3;
            req_store_type[d] = 2'd3;
            rdy_mode[d] = 2;
            in_rsp[d] = 1'b0;
        end

        #2 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_held");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("ready_after_reset_%0d", d), 32'(req_ready[d]), 32'd1);

        // Fill the low 256 bytes so every later load reads defined data
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) issue(d, 1'b1, 32'(w * 4), $urandom, 3'd0, 2'd3, 1'b0, '0, 1'b0);
            wait_drain(d);
        end

        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 2'd3, 1'b1, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 3'd3, 2'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b1, 32'h11, 32'h80, 3'd0, 2'd1, 1'b1, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h11, 32'h0, 3'd1, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0);
        issue(0, 1'b0, 32'h11, 32'h0, 3'd4, 2'd0, 1'b1, 32'h00000080, 1'b0);
        issue(0, 1'b0, 32'h12, 32'h0, 3'd2, 2'd0, 1'b1, 32'hFFFFDEAD, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 3'd5, 2'd0, 1'b1, 32'h000080EF, 1'b0);
        issue(0, 1'b0, 32'h13, 32'h0, 3'd3, 2'd0, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b1, 32'h21, 32'hFFFF, 3'd0, 2'd2, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b0, 32'h1000, 32'h0, 3'd3, 2'd0, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b0, 32'h11, 32'h0, 3'd5, 2'd0, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b0, 32'h10, 32'h0, 3'd7, 2'd0, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b1, 32'h20, 32'h1234, 3'd0, 2'd0, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b0, 32'h20, 32'h0, 3'd3, 2'd0, 1'b0, 32'h0, 1'b0);
        wait_drain(0);

        // Back-pressure: response must hold while rsp_ready stays low
        rdy_mode[0] = 1;
        issue(0, 1'b0, 32'h10, 32'h0, 3'd3, 2'd0, 1'b1, 32'hDEAD80EF, 1'b0);
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            n++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("hold_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        check("hold_req_ready", 32'(req_ready[0]), 32'd0);
        rdy_mode[0] = 2;
        wait_drain(0);
        @(negedge clk);
        check("post_handshake_req_ready", 32'(req_ready[0]), 32'd1);
        check("post_handshake_rsp_valid", 32'(rsp_valid[0]), 32'd0);

        issue(1, 1'b1, 32'h10, 32'hCAFEF00D, 3'd0, 2'd3, 1'b1, 32'h0, 1'b0);
        issue(1, 1'b0, 32'h10, 32'h0, 3'd3, 2'd0, 1'b1, 32'hCAFEF00D, 1'b0);
        wait_drain(1);

        // Reset in the middle of a pending store, then a pending load
        issue(0, 1'b1, 32'h40, 32'h12345678, 3'd0, 2'd3, 1'b1, 32'h0, 1'b0);
        reset_pulse_after_accept(0);
        issue(0, 1'b0, 32'h10, 32'h0, 3'd3, 2'd0, 1'b1, 32'hDEAD80EF, 1'b0);
        reset_pulse_after_accept(0);
        repeat (6) @(negedge clk);
        check("no_rsp_after_reset", 32'(rsp_valid[0]), 32'd0);
        issue(0, 1'b0, 32'h40, 32'h0, 3'd3, 2'd0, 1'b1, 32'h12345678, 1'b0);
        wait_drain(0);

        // Random traffic with random response back-pressure
        rdy_mode[0] = 0;
        rdy_mode[1] = 0;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 250; k++) begin
                wr = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) addr = 32'(BYTES) + 32'($urandom_range(0, 255));
                else addr = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
                lt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
                st = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
                issue(d, wr, addr, $urandom, lt, st, 1'b0, '0, 1'b0);
            end
            wait_drain(d);
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
